// File: rtl/imem_loader.sv
// imem_loader: streams a little-endian program image into a word array, then releases
// the processor reset and serves instructions combinationally from pc.
module imem_loader #(
  parameter int PROG_DEP = 256,
  parameter int IDX_WID  = 8
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        ld_valid,
  input  logic [7:0]  ld_data,
  output logic        ld_ready,
  input  logic [31:0] pc,
  output logic [31:0] inst,
  output logic        proc_nrst,
  output logic        done,
  output logic        ovf
);
  typedef enum logic [1:0] {CNT0, CNT1, DATA, RUN} state_t;
  localparam logic [16:0] DEP = 17'(PROG_DEP);
  state_t state;
  logic [15:0] wcnt, widx, cnt_full;
  logic [1:0] bsel;
  logic [31:0] word_buf, word_nxt;
  logic [31:0] mem [PROG_DEP];
  logic acc, wr, last;
  logic [IDX_WID-1:0] k;
  logic [16:0] lim;
  always_comb begin
    word_nxt = word_buf;
    word_nxt[8*bsel +: 8] = ld_data;
  end
  assign ld_ready = state != RUN;
  assign acc = ld_valid & ld_ready;
  assign cnt_full = {ld_data, wcnt[7:0]};
  assign last = widx + 16'd1 == wcnt;
  assign wr = acc && state == DATA && bsel == 2'd3 && {1'b0, widx} < DEP;
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      state     <= CNT0;
      wcnt      <= '0;
      widx      <= '0;
      bsel      <= '0;
      word_buf  <= '0;
      proc_nrst <= 1'b0;
      done      <= 1'b0;
      ovf       <= 1'b0;
    end else if (acc)
      case (state)
        CNT0: begin
          wcnt[7:0] <= ld_data;
          state     <= CNT1;
        end
        CNT1: begin
          wcnt[15:8] <= ld_data;
          state      <= cnt_full == '0 ? RUN : DATA;
          proc_nrst  <= cnt_full == '0;
          done       <= cnt_full == '0;
          if ({1'b0, cnt_full} > DEP) ovf <= 1'b1;
        end
        DATA: begin
          word_buf <= word_nxt;
          bsel     <= bsel + 2'd1;
          if (bsel == 2'd3) begin
            widx <= widx + 16'd1;
            if (last) begin
              state     <= RUN;
              proc_nrst <= 1'b1;
              done      <= 1'b1;
            end
          end
        end
        default: ;
      endcase
  // array is never cleared; stale words are hidden by the wcnt bound on reads
  always_ff @(posedge clk)
    if (wr) mem[widx[IDX_WID-1:0]] <= word_nxt;
  assign k = pc[IDX_WID+1:2];
  assign lim = {1'b0, wcnt} < DEP ? {1'b0, wcnt} : DEP;
  assign inst = state == RUN && pc[1:0] == 2'b00 && pc[31:IDX_WID+2] == '0 &&
                {{(17-IDX_WID){1'b0}}, k} < lim ? mem[k] : 32'h0000_0013;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: scoreboard bench for imem_loader against a byte-stream image model.
module tb_imem_loader;
  localparam int DEP = 256;
  logic clk = 0, nrst = 0, ld_valid = 0;
  logic [7:0] ld_data = 0;
  logic [31:0] pc = 0;
  logic ld_ready, proc_nrst, done, ovf;
  logic [31:0] inst;
  imem_loader #(.PROG_DEP(DEP), .IDX_WID(8)) dut (
    .clk(clk), .nrst(nrst), .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
    .pc(pc), .inst(inst), .proc_nrst(proc_nrst), .done(done), .ovf(ovf)
  );
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] inst;
    logic rdy, pn, dn, ov;
  } exp_t;
  exp_t eq[$];
  string nq[$];
  int checks = 0, failures = 0;
  logic probe = 0;

  logic [31:0] mmem [DEP];
  int m_cnt = 0;
  bit m_run = 0, m_ovf = 0;
  logic [7:0] img[$];

  function automatic logic [31:0] m_inst(logic [31:0] a);
    longint lim = m_cnt < DEP ? m_cnt : DEP;
    return (m_run && a % 4 == 0 && longint'(a / 4) < lim) ? mmem[a / 4] : 32'h13;
  endfunction

  task automatic expect_now(string nm);
    eq.push_back('{m_inst(pc), !m_run, m_run, m_run, m_ovf});
    nq.push_back(nm);
    probe = 1;
  endtask

  task automatic cmp(string n, string f, logic [31:0] a, logic [31:0] x);
    checks++;
    if (a !== x) begin
      failures++;
      $display("FAIL %s.%s got=%h exp=%h", n, f, a, x);
    end
  endtask

  always @(negedge clk) if (probe) begin
    exp_t e;
    string n;
    if (eq.size() == 0) begin
      checks++; failures++;
      $display("FAIL scoreboard_empty got=0 exp=1");
    end else begin
      e = eq.pop_front();
      n = nq.pop_front();
      cmp(n, "inst", inst, e.inst);
      cmp(n, "ld_ready", 32'(ld_ready), 32'(e.rdy));
      cmp(n, "proc_nrst", 32'(proc_nrst), 32'(e.pn));
      cmp(n, "done", 32'(done), 32'(e.dn));
      cmp(n, "ovf", 32'(ovf), 32'(e.ov));
    end
  end

  task automatic step();
    @(posedge clk); #1;
    probe = 0;
  endtask

  task automatic do_reset();
    step(); ld_valid = 0; nrst = 0;
    m_run = 0; m_cnt = 0; m_ovf = 0;
    expect_now("rst");
    step(); expect_now("rst_hold");
    step(); nrst = 1;
  endtask

  // thr: 0 = valid held high, 1 = idle cycle before every byte, 2 = random idles
  task automatic load(input int thr, input int stop_at);
    int n = img.size();
    for (int i = 0; i < n && i < stop_at; i++) begin
      if (thr == 1 || (thr == 2 && $urandom_range(0, 1) == 1)) begin
        step(); ld_valid = 0; pc = 0; expect_now("idle");
      end
      step(); ld_valid = 1; ld_data = img[i]; pc = 0; expect_now("byte");
      if (!m_run) begin
        if (i == 1) begin
          m_cnt = {img[1], img[0]};
          if (m_cnt > DEP) m_ovf = 1;
          if (m_cnt == 0) m_run = 1;
        end else if (i >= 2) begin
          int w = (i - 2) / 4, b = (i - 2) % 4;
          if (w < DEP) mmem[w][8*b +: 8] = img[i];
          if (b == 3 && w + 1 == m_cnt) m_run = 1;
        end
      end
    end
    step(); ld_valid = 0;
  endtask

  task automatic chk_pc(string nm, logic [31:0] a);
    step(); ld_valid = 0; pc = a; expect_now(nm);
  endtask

  task automatic rand_img(int nw);
    img.delete();
    img.push_back(8'(nw)); img.push_back(8'(nw >> 8));
    for (int i = 0; i < 4 * nw; i++) img.push_back(8'($urandom));
  endtask

  initial begin
    int nw;
    do_reset();
    img = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'ha0, 8'h00};
    load(0, 99);
    chk_pc("basic_pc0", 0); chk_pc("basic_pc4", 4); chk_pc("basic_pc8", 8);
    chk_pc("misaligned", 32'h2); chk_pc("out_of_range", 32'h400);
    img = '{8'h01, 8'h00, 8'hff, 8'hff, 8'hff, 8'hff};
    load(0, 99);
    chk_pc("run_ignores_pc0", 0);
    do_reset();
    img = '{8'h00, 8'h00};
    load(0, 99);
    chk_pc("zero_pc0", 0);
    do_reset();
    img = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'ha0, 8'h00};
    load(1, 99);
    chk_pc("thr_pc0", 0); chk_pc("thr_pc4", 4); chk_pc("thr_pc8", 8);
    do_reset();
    load(0, 5);
    do_reset();
    img = '{8'h01, 8'h00, 8'hb3, 8'h01, 8'h31, 8'h00};
    load(0, 99);
    chk_pc("reload_pc0", 0); chk_pc("reload_pc4", 4);
    do_reset();
    rand_img(DEP + 1);
    load(0, 9999);
    chk_pc("ovf_pc0", 0); chk_pc("ovf_last", 32'h3fc); chk_pc("ovf_beyond", 32'h400);
    repeat (6) begin
      do_reset();
      nw = $urandom_range(1, 12);
      rand_img(nw);
      load(2, 9999);
      for (int j = 0; j <= nw + 1; j++) chk_pc("rand_word", 32'(4 * j));
      repeat (4) chk_pc("rand_pc", $urandom_range(0, 1100));
      chk_pc("rand_wide_pc", $urandom);
    end
    do_reset();
    step();
    for (int t = 0; t < 10 && eq.size() != 0; t++) step();
    checks++;
    if (eq.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d exp=0", eq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
